// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: combinational write-enable/flush steering
// plus a memory-wait watchdog FSM and saturating stall/flush performance counters.
module pipeline_stall_controller #(
    parameter int unsigned WAIT_LIMIT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_stall,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    localparam logic [7:0] LP_LIMIT = 8'(WAIT_LIMIT);

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_freeze;

    assign w_freeze    = dmem_req & ~dmem_ready;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

    // Reset, ERROR and a pending memory access all share the frozen output pattern.
    always_comb begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_we      = 1'b0;
        idex_flush   = 1'b0;
        exmem_we     = 1'b0;
        memwb_bubble = 1'b1;
        if (rst_n && (r_state != ST_ERROR) && !w_freeze) begin
            memwb_bubble = 1'b0;
            idex_we      = 1'b1;
            exmem_we     = 1'b1;
            if (ex_branch_taken) begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_stall) begin
                idex_flush = 1'b1;
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_freeze) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt >= LP_LIMIT) begin
                        r_state       <= ST_ERROR;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_RUN;
            endcase

            if (r_state != ST_ERROR) begin
                if (!pc_we && (r_stall_cnt != '1))
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (ifid_flush && (r_flush_cnt != '1))
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
